// File: rtl/apb_completer_mem.sv
// apb_completer_mem: APB4/APB5 memory-backed completer with programmable wait states and PSLVERR on out-of-range; COMPLETER_PROT_CHECK_EN makes the upper half privileged-only
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module apb_completer_mem #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int MEM_DEPTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_WIDTH = 4
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [2:0]              pprot,
  input  logic                    pnse,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  input  logic                    pwakeup,
  input  logic [WAIT_WIDTH-1:0]   cfg_wait
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx, rd_idx;
  logic wr_q, err_q, hit, err, setup, commit, rd_err, rd_wr;
  logic [DATA_WIDTH-1:0] wdata_q, prdata_q, prdata_d;
  logic [NB-1:0] strb_q;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic pready_q, pready_d, pslverr_q, pslverr_d;
  logic [ADDR_WIDTH-1:0] off, idx_full;
  logic unused_in;
  assign off = paddr - BASE_ADDR;
  assign idx_full = off >> LSB;
  assign idx = idx_full[IW-1:0];
  assign hit = (paddr >= BASE_ADDR) && (idx_full < ADDR_WIDTH'(MEM_DEPTH));
`ifdef COMPLETER_PROT_CHECK_EN
  assign err = !hit || (idx[IW-1] && !pprot[0]);
`else
  assign err = !hit;
`endif
  assign unused_in = ^{pnse, pwakeup, pprot};
  assign setup = psel && !penable;
  // Next state: setup from IDLE loads the wait count, WAIT counts down to RESP, RESP always returns to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (setup) begin
        cnt_d = cfg_wait;
        state_d = (cfg_wait == '0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        state_d = !psel ? IDLE : (cnt_q == WAIT_WIDTH'(1)) ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // Response is built on the edge entering RESP; a zero-wait transfer uses the live decode instead of the latched one
  always_comb begin
    rd_idx = (state_q == IDLE) ? idx : idx_q;
    rd_err = (state_q == IDLE) ? err : err_q;
    rd_wr = (state_q == IDLE) ? pwrite : wr_q;
    pready_d = (state_d == RESP) && (state_q != RESP);
    pslverr_d = pready_d && rd_err;
    prdata_d = (pready_d && !rd_err && !rd_wr) ? mem_q[rd_idx] : '0;
    commit = (state_q == RESP) && psel && wr_q && !err_q;
  end
  // State, counter and registered response outputs
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end
  // Transfer attributes captured in the setup phase; later bus changes are ignored
  always_ff @(posedge pclk) begin
    if (state_q == IDLE && setup) begin
      idx_q <= idx;
      wr_q <= pwrite;
      err_q <= err;
      wdata_q <= pwdata;
      strb_q <= pstrb;
    end
  end
  // Storage array: cleared by reset, byte-lane write on the edge leaving RESP
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      for (int b = 0; b < NB; b++) if (strb_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end
  assign pready = pready_q;
  assign prdata = prdata_q;
  assign pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_completer_mem.sv
// tb_apb_completer_mem: randomized self-checking bench for apb_completer_mem against a word-array reference model
module tb_apb_completer_mem;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic clk = 1'b0, preset = 1'b1;
  logic [31:0] paddr = '0, pwdata = '0, prdata;
  logic [2:0] pprot = '0;
  logic pnse = 1'b0, psel = 1'b0, penable = 1'b0, pwrite = 1'b0, pwakeup = 1'b0;
  logic [3:0] pstrb = '0, cfg_wait = '0;
  logic pready, pslverr;
  int tests = 0, fails = 0;
  logic [31:0] mdl [16];

  apb_completer_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16), .BASE_ADDR(BASE), .WAIT_WIDTH(4)) dut (
    .pclk(clk), .preset(preset), .paddr(paddr), .pprot(pprot), .pnse(pnse), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .pwakeup(pwakeup), .cfg_wait(cfg_wait));

  always #5 clk = ~clk;

  function automatic bit m_err(input logic [31:0] a, input logic [2:0] p);
    logic [31:0] w;
    w = (a - BASE) / 4;
    if (a < BASE || w >= 16) return 1'b1;
`ifdef COMPLETER_PROT_CHECK_EN
    if (w >= 8 && !p[0]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4) % 16;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [2:0] p);
    return m_err(a, p) ? 32'h0 : mdl[m_idx(a)];
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    if (!m_err(a, p))
      for (int b = 0; b < 4; b++) if (s[b]) mdl[m_idx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic m_clear();
    for (int i = 0; i < 16; i++) mdl[i] = '0;
  endtask

  // One transfer starting at the next negedge; leaves psel high so a following call is back-to-back
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [3:0] w, input logic [2:0] p,
                      output logic [31:0] rd, output logic err, output int cyc);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; cfg_wait = w; pprot = p;
    @(negedge clk);
    penable = 1'b1; cfg_wait = 4'($urandom);
    cyc = 1;
    while (pready !== 1'b1 && cyc <= int'(w) + 4) begin
      paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom);
      @(negedge clk);
      cyc++;
    end
    rd = prdata; err = pslverr;
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic e; int c;
    preset = 1'b1; psel = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (pready !== 1'b0) begin fails++; $display("FAIL reset_pready got %b want 0", pready); end
    tests++; if (prdata !== 32'h0) begin fails++; $display("FAIL reset_prdata got %h want 0", prdata); end
    tests++; if (pslverr !== 1'b0) begin fails++; $display("FAIL reset_pslverr got %b want 0", pslverr); end
    preset = 1'b0;
    m_clear();
    xfer(0, BASE + 12, 32'h0, 4'h0, 4'd0, 3'b000, rd, e, c);
    tests++; if (rd !== m_read(BASE + 12, 3'b000)) begin fails++; $display("FAIL reset_read3 got %h want %h", rd, m_read(BASE + 12, 3'b000)); end
    idle();
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic e; int c;
    xfer(1, BASE + 8, 32'hDEADBEEF, 4'hF, 4'd0, 3'b000, rd, e, c);
    m_write(BASE + 8, 32'hDEADBEEF, 4'hF, 3'b000);
    tests++; if (c !== 1 || e !== 1'b0) begin fails++; $display("FAIL zw_write cycles=%0d err=%b want 1/0", c, e); end
    xfer(0, BASE + 8, 32'h0, 4'h0, 4'd0, 3'b000, rd, e, c);
    tests++; if (c !== 1 || e !== 1'b0) begin fails++; $display("FAIL zw_read cycles=%0d err=%b want 1/0", c, e); end
    tests++; if (rd !== m_read(BASE + 8, 3'b000)) begin fails++; $display("FAIL zw_data got %h want %h", rd, m_read(BASE + 8, 3'b000)); end
    idle();
    tests++; if ({pready, pslverr, prdata} !== 34'h0) begin fails++; $display("FAIL zw_idle got %b%b %h want 0", pready, pslverr, prdata); end
  endtask

  task automatic test_wait_strobes();
    logic [31:0] rd; logic e; int c;
    xfer(1, BASE + 8, 32'h11223344, 4'b0101, 4'd3, 3'b000, rd, e, c);
    m_write(BASE + 8, 32'h11223344, 4'b0101, 3'b000);
    tests++; if (c !== 4) begin fails++; $display("FAIL ws_latency got %0d want 4", c); end
    xfer(0, BASE + 8, 32'h0, 4'h0, 4'd2, 3'b000, rd, e, c);
    tests++; if (c !== 3) begin fails++; $display("FAIL ws_read_latency got %0d want 3", c); end
    tests++; if (rd !== m_read(BASE + 8, 3'b000)) begin fails++; $display("FAIL ws_data got %h want %h", rd, m_read(BASE + 8, 3'b000)); end
    xfer(1, BASE + 8, 32'hFFFFFFFF, 4'h0, 4'd0, 3'b000, rd, e, c);
    xfer(0, BASE + 8, 32'h0, 4'h0, 4'd0, 3'b000, rd, e, c);
    tests++; if (rd !== m_read(BASE + 8, 3'b000)) begin fails++; $display("FAIL ws_zero_strobe got %h want %h", rd, m_read(BASE + 8, 3'b000)); end
    idle();
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic e; int c;
    xfer(1, BASE + 60, 32'h5A5A1234, 4'hF, 4'd1, 3'b001, rd, e, c);
    m_write(BASE + 60, 32'h5A5A1234, 4'hF, 3'b001);
    xfer(0, BASE + 64, 32'h0, 4'h0, 4'd0, 3'b001, rd, e, c);
    tests++; if (e !== 1'b1 || rd !== 32'h0 || c !== 1) begin fails++; $display("FAIL oor_read err=%b data=%h cycles=%0d want 1/0/1", e, rd, c); end
    xfer(1, BASE + 64, 32'hFFFFFFFF, 4'hF, 4'd2, 3'b001, rd, e, c);
    tests++; if (e !== 1'b1 || rd !== 32'h0 || c !== 3) begin fails++; $display("FAIL oor_write err=%b data=%h cycles=%0d want 1/0/3", e, rd, c); end
    xfer(1, BASE - 4, 32'hFFFFFFFF, 4'hF, 4'd0, 3'b001, rd, e, c);
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL below_base err=%b want 1", e); end
    xfer(0, BASE + 60, 32'h0, 4'h0, 4'd0, 3'b001, rd, e, c);
    tests++; if (rd !== m_read(BASE + 60, 3'b001) || e !== 1'b0) begin fails++; $display("FAIL oor_word15 got %h want %h", rd, m_read(BASE + 60, 3'b001)); end
    idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic e; int c;
    xfer(1, BASE + 20, 32'h0BADF00D, 4'hF, 4'd0, 3'b000, rd, e, c);
    m_write(BASE + 20, 32'h0BADF00D, 4'hF, 3'b000);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 20; pwdata = 32'h12345678; pstrb = 4'hF; cfg_wait = 4'd5;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (pready !== 1'b0) begin fails++; $display("FAIL abort_pready cycle %0d got %b want 0", i, pready); end
    end
    xfer(0, BASE + 20, 32'h0, 4'h0, 4'd0, 3'b000, rd, e, c);
    tests++; if (rd !== m_read(BASE + 20, 3'b000)) begin fails++; $display("FAIL abort_nowrite got %h want %h", rd, m_read(BASE + 20, 3'b000)); end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int c;
    xfer(1, BASE + 4, 32'hA5A50001, 4'hF, 4'd0, 3'b000, rd, e, c);
    m_write(BASE + 4, 32'hA5A50001, 4'hF, 3'b000);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 4; pwdata = 32'h77777777; pstrb = 4'hF; cfg_wait = 4'd5;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    preset = 1'b1; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    tests++; if ({pready, pslverr, prdata} !== 34'h0) begin fails++; $display("FAIL rst_mid_out got %b%b %h want 0", pready, pslverr, prdata); end
    preset = 1'b0;
    m_clear();
    xfer(0, BASE + 4, 32'h0, 4'h0, 4'd1, 3'b000, rd, e, c);
    tests++; if (rd !== m_read(BASE + 4, 3'b000) || c !== 2) begin fails++; $display("FAIL rst_mid_cleared got %h/%0d want %h/2", rd, c, m_read(BASE + 4, 3'b000)); end
    idle();
  endtask

  task automatic test_prot();
    logic [31:0] rd; logic e; int c;
    xfer(1, BASE + 48, 32'hCAFE0001, 4'hF, 4'd1, 3'b000, rd, e, c);
    tests++; if (e !== m_err(BASE + 48, 3'b000)) begin fails++; $display("FAIL prot_user_err got %b want %b", e, m_err(BASE + 48, 3'b000)); end
    m_write(BASE + 48, 32'hCAFE0001, 4'hF, 3'b000);
    xfer(0, BASE + 48, 32'h0, 4'h0, 4'd0, 3'b001, rd, e, c);
    tests++; if (rd !== m_read(BASE + 48, 3'b001)) begin fails++; $display("FAIL prot_user_word got %h want %h", rd, m_read(BASE + 48, 3'b001)); end
    xfer(1, BASE + 48, 32'hCAFE0002, 4'hF, 4'd0, 3'b001, rd, e, c);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL prot_priv_err got %b want 0", e); end
    m_write(BASE + 48, 32'hCAFE0002, 4'hF, 3'b001);
    xfer(0, BASE + 48, 32'h0, 4'h0, 4'd0, 3'b001, rd, e, c);
    tests++; if (rd !== m_read(BASE + 48, 3'b001)) begin fails++; $display("FAIL prot_priv_word got %h want %h", rd, m_read(BASE + 48, 3'b001)); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; int c;
    xfer(1, BASE + 28, 32'h31415926, 4'hF, 4'd0, 3'b000, rd, e, c);
    m_write(BASE + 28, 32'h31415926, 4'hF, 3'b000);
    xfer(0, BASE + 28, 32'h0, 4'h0, 4'd0, 3'b000, rd, e, c);
    tests++; if (rd !== m_read(BASE + 28, 3'b000) || c !== 1) begin fails++; $display("FAIL b2b got %h/%0d want %h/1", rd, c, m_read(BASE + 28, 3'b000)); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp_rd; logic e, wr, exp_err; logic [3:0] s, w; logic [2:0] p; int c;
    for (int n = 0; n < 80; n++) begin
      a = BASE + 32'($signed($urandom_range(19)) - 2) * 4 + 32'($urandom_range(3));
      wr = 1'($urandom); d = $urandom; s = 4'($urandom); w = 4'($urandom_range(3)); p = 3'($urandom);
      exp_err = m_err(a, p);
      exp_rd = (wr || exp_err) ? 32'h0 : m_read(a, p);
      xfer(wr, a, d, s, w, p, rd, e, c);
      if (wr) m_write(a, d, s, p);
      tests++;
      if (c !== int'(w) + 1 || e !== exp_err || (!wr && rd !== exp_rd) || (exp_err && rd !== 32'h0)) begin
        fails++;
        $display("FAIL rand[%0d] wr=%b a=%h cycles=%0d err=%b data=%h want cycles=%0d err=%b data=%h", n, wr, a, c, e, rd, int'(w) + 1, exp_err, exp_rd);
      end
      if ($urandom_range(3) == 0) idle();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_strobes();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    test_prot();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/apb_completer_mem.md
Name: apb_completer_mem

Overview:
- Parametrised APB4/APB5 completer model for the crossbar testbench; next generation of the fixed-response completer.
- Backs transfers with a word-addressed register array and supports byte strobes.
- Inserts a runtime-programmable number of wait states and returns PSLVERR on out-of-range addresses.
- Instantiated once per completer port of the interconnect DUT.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH: paddr width.
- DATA_WIDTH, `DATA_WIDTH: pwdata/prdata width; multiple of 8, power of 2.
- MEM_DEPTH, 16: number of DATA_WIDTH words in the array; power of 2, >= 2.
- BASE_ADDR, 0: byte address of word 0; aligned to DATA_WIDTH/8.
- WAIT_WIDTH, 4: width of cfg_wait.

Ports:
- pclk  input  1  APB clock; all logic on rising edge.
- preset  input  1  synchronous, active-high reset.
- paddr  input  ADDR_WIDTH  byte address.
- pprot  input  3  protection attributes.
- pnse  input  1  non-secure extension; ignored.
- psel  input  1  completer select.
- penable  input  1  access phase.
- pwrite  input  1  1 = write, 0 = read.
- pwdata  input  DATA_WIDTH  write data.
- pstrb  input  DATA_WIDTH/8  write byte strobes.
- pready  output  1  transfer complete (registered).
- prdata  output  DATA_WIDTH  read data (registered).
- pslverr  output  1  error response (registered).
- pwakeup  input  1  ignored.
- cfg_wait  input  WAIT_WIDTH  wait states for the next transfer; sampled in the setup phase.

Behaviour:
- Reset (preset=1 at a rising edge):
  - state=IDLE; pready=0, prdata=0, pslverr=0.
  - Wait counter=0; every memory word=0.
  - Reset overrides any transfer in progress; no write commits on that edge.
- Address decode:
  - off = paddr - BASE_ADDR (ADDR_WIDTH, unsigned).
  - idx = off >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored.
  - hit = (paddr >= BASE_ADDR) && (idx < MEM_DEPTH).
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on an edge with psel=1 and penable=0 (setup), latch paddr, pwrite, pwdata, pstrb, pprot, hit and cnt=cfg_wait. Next state is RESP if cfg_wait==0, else WAIT. psel=1 with penable=1 in IDLE is a protocol violation: ignore it and stay in IDLE.
  - WAIT: cnt decrements each edge; when cnt==1, go to RESP.
  - RESP: pready=1 for exactly one cycle, then IDLE. In that cycle pready, prdata and pslverr are presented together.
- Latency: access-phase length = cfg_wait + 1 cycles. cfg_wait=0 gives the zero-wait-state transfer (pready high in the first access cycle).
- Write commit: on the edge leaving RESP, if hit and no error, mem[idx] byte lane b <= pwdata lane b for each pstrb[b]=1. Lanes with pstrb[b]=0 are unchanged. pstrb=0 is legal and changes nothing.
- Read: prdata = mem[idx] when hit, else 0. Value is read when entering RESP. pstrb is ignored on reads.
- Outside RESP: pready=0, prdata=0, pslverr=0.
- pslverr=1 in RESP when !hit (or the protection check fails). The array is not modified on error.
- Abort: psel=0 in WAIT or RESP returns to IDLE on the next edge with outputs 0 and no write.
- Back-to-back: a setup phase in the cycle directly after RESP (psel held, penable=0) is accepted from IDLE with no idle gap.
- Address/controls changing during WAIT are ignored; the latched values are used.

Optional Feature:
- Macro: COMPLETER_PROT_CHECK_EN.
- Defined: words idx >= MEM_DEPTH/2 are privileged-only. An in-range access to them with latched pprot[0]==0 returns pslverr=1, prdata=0 and no write.
- Undefined: pprot is ignored and all in-range accesses succeed.

Test Plan:
- Reset then idle: preset=1 for 2 cycles, psel=0 -> pready=0, prdata=0, pslverr=0. Read of idx 3 returns 0.
- Zero-wait write/read: cfg_wait=0; write paddr=BASE_ADDR+8, pwdata=32'hDEADBEEF, pstrb=4'hF; then read the same address -> pready high in the first access cycle both times, prdata=32'hDEADBEEF, pslverr=0.
- Wait states and strobes: cfg_wait=3; write 32'h11223344 with pstrb=4'b0101 over 32'hDEADBEEF -> pready asserts on the 4th access cycle. Readback gives 32'hDE22BE44.
- Out of range: DATA_WIDTH=32, MEM_DEPTH=16; read and write at paddr=BASE_ADDR+64 -> pslverr=1 with pready, prdata=0. Word 15 is unchanged.
- Abort and reset mid-op:
  - cfg_wait=5; drop psel on the 2nd access cycle -> no pready, no write.
  - Repeat, but assert preset in WAIT instead -> outputs 0 next cycle and the array is cleared.
- Protection check, with COMPLETER_PROT_CHECK_EN defined and MEM_DEPTH=16:
  - Write idx 12 with pprot=3'b000 -> pslverr=1, word unchanged.
  - Same write with pprot=3'b001 -> pslverr=0, word updated.
